register_read_port: RTL and testbench

- Read-side controller for a bank of NUM_REGS 16-bit write-enabled registers; the register instances remain the write side.
- Accepts single or burst read requests over a valid/ready handshake.
- Selects words from the flattened register bus and returns them through a registered response stage with backpressure.
- Sits between the register bank and the datapath/debug consumers of register contents.

---
 rtl/register_read_port.sv | 144 ++++++++++++++
 tb/tb_register_read_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_read_port.sv
// -----------------------------------------------------------------------------
// register_read_port
//
// Read-side controller for a bank of NUM_REGS 16-bit registers. Accepts single
// or burst read requests over a valid/ready handshake, selects words from the
// flattened register bus and returns them through a registered response stage
// that honours consumer backpressure (full throughput: one word per cycle).
//
// Ports:
//   clock       - clock, all state updates on posedge
//   reset       - asynchronous, active-high reset
//   reg_bus     - stored value of every register, reg i at [16*i+15:16*i]
//   wr_en       - snooped write strobe of the bank
//   wr_addr     - index of the register being written
//   wr_val      - value being written
//   req_valid   - request present
//   req_ready   - request can be accepted this cycle
//   req_addr    - start register index
//   req_len     - burst length minus one (0 = single read)
//   resp_valid  - rd_data is valid
//   resp_ready  - consumer accepts the response this cycle
//   rd_data     - returned register word
//   rd_last     - final word of a request
//   busy        - burst in progress or response pending
//
// Build option:
//   REG_READ_BYPASS_EN - when defined, a word issued on the same edge as a
//   write to that register returns the value being written (wr_val) instead
//   of the old reg_bus contents. Handshake timing is identical either way.
// -----------------------------------------------------------------------------
module register_read_port #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [16*NUM_REGS-1:0] reg_bus,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [15:0]            wr_val,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [ADDR_W-1:0]      req_len,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [15:0]            rd_data,
    output logic                   rd_last,
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   remaining;

    logic                out_free;
    logic                accept;
    logic                burst_issue;
    logic                issue;
    logic [ADDR_W-1:0]   issue_addr;
    logic [15:0]         issue_word;
    logic                issue_last;

    // Output stage can take a new word if empty or being popped this cycle.
    assign out_free    = !resp_valid || resp_ready;
    assign accept      = req_valid && req_ready;
    assign burst_issue = (state == BURST) && out_free;
    assign issue       = accept || burst_issue;
    assign issue_addr  = (state == IDLE) ? req_addr : cur_addr;
    // remaining counts words still owed after the one being issued, so the
    // last word of a burst is the one issued while remaining is 1.
    assign issue_last  = (state == IDLE) ? (req_len == '0)
                                         : (remaining == ADDR_W'(1));

    // Word select, with optional write bypass.
    always_comb begin
        // NOTE: default assignment first so no path leaves issue_word unassigned (no latch).
        issue_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_addr == ADDR_W'(i))
                issue_word = reg_bus[16*i +: 16];
        end
`ifdef REG_READ_BYPASS_EN
        if (wr_en && (wr_addr == issue_addr))
            issue_word = wr_val;
`endif
    end

`ifndef REG_READ_BYPASS_EN
    // Write snoop is only needed by the bypass build.
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_val};
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept && (req_len != '0))     state_nxt = BURST;
            BURST: if (burst_issue && issue_last)     state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    // Response stage and burst bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            cur_addr   <= '0;
            remaining  <= '0;
        end else if (issue) begin
            resp_valid <= 1'b1;
            rd_data    <= issue_word;
            rd_last    <= issue_last;
            cur_addr   <= issue_addr + ADDR_W'(1);   // wraps mod NUM_REGS
            remaining  <= accept ? req_len : remaining - ADDR_W'(1);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Outputs.
    always_comb begin
        req_ready = (state == IDLE) && out_free;
        busy      = (state == BURST) || resp_valid;
    end

endmodule

// File: tb/tb_register_read_port.sv
// -----------------------------------------------------------------------------
// tb_register_read_port
//
// Self-checking bench for register_read_port. A behavioural model tracks the
// bank contents, the number of words still owed to the consumer and the
// content of the response slot, and predicts every visible output each cycle.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_register_read_port;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [16*NUM_REGS-1:0] reg_bus;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [15:0]            wr_val;
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_addr;
    logic [ADDR_W-1:0]      req_len;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [15:0]            rd_data;
    logic                   rd_last;
    logic                   busy;

    register_read_port #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .reg_bus    (reg_bus),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_val     (wr_val),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Bank contents, driven onto reg_bus.
    logic [15:0] regs [NUM_REGS];
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            reg_bus[16*i +: 16] = regs[i];
    end

    // Reference model state.
    bit          m_valid;
    bit          m_last;
    logic [15:0] m_data;
    int          m_left;     // words of the current request not yet issued
    int          m_next;     // next register index to issue
    bit          last_acc;   // request was taken on the last edge

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_last  = 0;
        m_data  = '0;
        m_left  = 0;
        m_next  = 0;
    endtask

    // One clock: check outputs against the model, take the edge, advance the
    // model and apply the bank write. Inputs are set by the caller beforehand.
    task automatic cycle();
        bit          free;
        logic [15:0] w;
        #1;
        free = !m_valid || resp_ready;
        chk("req_ready", 32'(req_ready), 32'((m_left == 0) && free));
        chk("busy", 32'(busy), 32'((m_left != 0) || m_valid));
        chk("resp_valid", 32'(resp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rd_data", 32'(rd_data), 32'(m_data));
            chk("rd_last", 32'(rd_last), 32'(m_last));
        end
        @(posedge clock);
        #1;
        last_acc = 0;
        if (free) begin
            if (m_left == 0 && req_valid) begin
                m_next   = int'(req_addr);
                m_left   = int'(req_len) + 1;
                last_acc = 1;
            end
            if (m_left > 0) begin
                w = regs[m_next];
`ifdef REG_READ_BYPASS_EN
                if (wr_en && int'(wr_addr) == m_next) w = wr_val;
`endif
                m_data  = w;
                m_left  = m_left - 1;
                m_last  = (m_left == 0);
                m_next  = (m_next + 1) % NUM_REGS;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        if (wr_en) regs[wr_addr] = wr_val;
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        req_valid  = 0;
        req_addr   = '0;
        req_len    = '0;
        wr_en      = 0;
        wr_addr    = '0;
        wr_val     = '0;
        resp_ready = 1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'(i);
        regs[2] = 16'hBEEF;
        regs[3] = 16'h1111;
        regs[5] = 16'h5555;
        idle_inputs();
        model_reset();
        reset = 1;
        repeat (2) @(negedge clock);

        // Reset state.
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        chk("rst rd_last", 32'(rd_last), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        reset = 0;

        // Single read of r2.
        req_valid = 1; req_addr = 3'd2; req_len = '0;
        cycle();
        req_valid = 0;
        #1;
        chk("single data", 32'(rd_data), 32'hBEEF);
        chk("single last", 32'(rd_last), 32'd1);
        cycle();
        cycle();

        // Burst r6..r1 with wrap, full throughput.
        req_valid = 1; req_addr = 3'd6; req_len = 3'd3;
        cycle();
        req_valid = 0;
        repeat (5) cycle();

        // Same burst with backpressure after the second word.
        req_valid = 1; req_addr = 3'd6; req_len = 3'd3;
        cycle();
        req_valid = 0;
        cycle();                       // second word now presented
        resp_ready = 0;
        repeat (3) cycle();
        #1;
        chk("bp hold data", 32'(rd_data), 32'h0007);
        resp_ready = 1;
        repeat (4) cycle();

        // Read r3 on the same edge as a write to r3.
        req_valid = 1; req_addr = 3'd3; req_len = '0;
        wr_en = 1; wr_addr = 3'd3; wr_val = 16'h2222;
        cycle();
        idle_inputs();
        #1;
`ifdef REG_READ_BYPASS_EN
        chk("write same edge", 32'(rd_data), 32'h2222);
`else
        chk("write same edge", 32'(rd_data), 32'h1111);
`endif
        cycle();

        // Reset during the second word of an 8-word burst.
        req_valid = 1; req_addr = 3'd0; req_len = 3'd7;
        cycle();
        req_valid = 0;
        cycle();
        #2;
        reset = 1;
        #1;
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst rd_last", 32'(rd_last), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 0;
        req_valid = 1; req_addr = 3'd5; req_len = '0;
        cycle();
        req_valid = 0;
        #1;
        chk("post rst data", 32'(rd_data), 32'h5555);
        chk("post rst last", 32'(rd_last), 32'd1);
        cycle();

        // Back-to-back single reads r1 then r4, req_valid held.
        req_valid = 1; req_addr = 3'd1; req_len = '0;
        cycle();
        req_addr = 3'd4;
        #1;
        chk("b2b ready", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 0;
        cycle();
        cycle();

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            if (!req_valid || last_acc) begin
                req_valid = ($urandom_range(0, 2) != 0);
                req_addr  = ADDR_W'($urandom);
                req_len   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 2));
            end
            resp_ready = ($urandom_range(0, 9) < 7);
            wr_en      = ($urandom_range(0, 9) < 3);
            wr_addr    = ADDR_W'($urandom);
            wr_val     = 16'($urandom);
            cycle();
        end
        idle_inputs();
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
